// File: rtl/channelizer_dpram_reader.sv
// Purpose : read-side burst sequencer for the channelizer dual-port RAM (port B) with valid/ready output.
// Latency : first dout_valid latency+1 ce-cycles after an accepted start; 1 word/ce-cycle sustained.
// Backpr. : credit-checked skid FIFO of latency+2 words; reads stall when in-flight + stored reach depth.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   ce                   global clock enable; every register holds when low
//   start/base_addr/len  burst request (sampled in IDLE only), first address, word count 0..2**aw
//   busy, done           burst in progress / one-cycle completion pulse
//   ram_addr, ram_en     to RAM addrb/enb; ram_dout from RAM doutb
//   dout, dout_valid     registered FIFO head; dout_ready accepts it
// Optional feature: define CHANNELIZER_DPRAM_READER_LAST_EN to add dout_last, which marks the final
// word of each burst and travels through the FIFO alongside the data.
module channelizer_dpram_reader #(
    parameter int c_width         = 13,
    parameter int c_address_width = 4,
    parameter int latency         = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       start,
    input  logic [c_address_width-1:0] base_addr,
    input  logic [c_address_width:0]   len,
    output logic                       busy,
    output logic                       done,
    output logic [c_address_width-1:0] ram_addr,
    output logic                       ram_en,
    input  logic [c_width-1:0]         ram_dout,
    output logic [c_width-1:0]         dout,
    output logic                       dout_valid,
`ifdef CHANNELIZER_DPRAM_READER_LAST_EN
    output logic                       dout_last,
`endif
    input  logic                       dout_ready
);

    // Depth covers every read that can be in the RAM pipeline plus the word at the head
    // and one more, so a full pipeline can always land even while the head stalls.
    localparam int depth = latency + 2;
    localparam int pw    = $clog2(depth);
    localparam int cw    = $clog2(depth + 1);

    localparam logic [pw-1:0] ptr_last   = pw'(depth - 1);
    localparam logic [cw-1:0] depth_c    = cw'(depth);
    localparam logic [cw:0]   credit_lim = (cw + 1)'(depth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [c_address_width-1:0] addr;
    logic [c_address_width:0]   remaining;
    logic [latency-1:0]         vpipe;
    logic [cw-1:0]              inflight;
    logic [cw-1:0]              fifo_count;
    logic [cw-1:0]              count_nxt;
    logic [pw-1:0]              wr_ptr;
    logic [pw-1:0]              rd_ptr;
    logic [pw-1:0]              rd_ptr_nxt;
    logic [c_width-1:0]         fifo_mem [depth];
    logic                       issue;
    logic                       done_nxt;
    logic                       credit_ok;
    logic                       fifo_wr;
    logic                       fifo_rd;
    logic                       head_from_wr;

    function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
        return (p == ptr_last) ? '0 : p + pw'(1);
    endfunction

    assign busy     = (state != IDLE);
    assign ram_en   = ce & busy;
    assign ram_addr = addr;

    // Conservative credit: a word popped this cycle is not counted as freed until next cycle.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < credit_lim;

    assign fifo_wr    = ce & vpipe[latency-1];
    assign fifo_rd    = ce & dout_valid & dout_ready;
    assign count_nxt  = fifo_count + cw'(fifo_wr) - cw'(fifo_rd);
    assign rd_ptr_nxt = fifo_rd ? ptr_inc(rd_ptr) : rd_ptr;

    // The next head is the word being written when the FIFO would otherwise be empty.
    assign head_from_wr = fifo_wr && (wr_ptr == rd_ptr_nxt);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        if (ce) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = READ;
                        end
                    end
                end
                READ: begin
                    if (credit_ok) begin
                        issue = 1'b1;
                        if (remaining == (c_address_width + 1)'(1)) begin
                            state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Everything is issued; with nothing in flight the lone stored word is the last.
                    if (fifo_rd && fifo_count == cw'(1) && inflight == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            addr       <= '0;
            remaining  <= '0;
            vpipe      <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (ce) begin
            state <= state_nxt;
            done  <= done_nxt;
            if (state == IDLE && start) begin
                addr      <= base_addr;
                remaining <= len;
            end else if (issue) begin
                addr      <= addr + c_address_width'(1);
                remaining <= remaining - (c_address_width + 1)'(1);
            end
            vpipe[0] <= issue;
            for (int i = 1; i < latency; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            inflight   <= inflight + cw'(issue) - cw'(fifo_wr);
            fifo_count <= count_nxt;
            if (fifo_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr     <= rd_ptr_nxt;
            dout_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                dout <= head_from_wr ? ram_dout : fifo_mem[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= ram_dout;
        end
    end

`ifdef CHANNELIZER_DPRAM_READER_LAST_EN
    logic [latency-1:0] lpipe;
    logic               fifo_last [depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lpipe     <= '0;
            dout_last <= 1'b0;
        end else if (ce) begin
            lpipe[0] <= issue && (remaining == (c_address_width + 1)'(1));
            for (int i = 1; i < latency; i++) begin
                lpipe[i] <= lpipe[i-1];
            end
            if (count_nxt != '0) begin
                dout_last <= head_from_wr ? lpipe[latency-1] : fifo_last[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_last[wr_ptr] <= lpipe[latency-1];
        end
    end
`endif

`ifndef SYNTHESIS
    // A write into a full FIFO without a matching pop means the credit check is broken.
    always @(posedge clk) begin
        if (!rst && fifo_wr && !fifo_rd) begin
            assert (fifo_count != depth_c);
        end
    end
`endif

endmodule

// File: tb/tb_channelizer_dpram_reader.sv
`timescale 1ns/1ps
module tb_channelizer_dpram_reader;

    logic        clk = 1'b0;
    logic        rst, ce, start, dout_ready;
    logic [3:0]  base_addr;
    logic [4:0]  len;

    logic        busy1, done1, en1, valid1;
    logic [3:0]  addr1;
    logic [12:0] rd1, dout1;
    logic        busy3, done3, en3, valid3;
    logic [3:0]  addr3;
    logic [12:0] rd3, dout3;
`ifdef CHANNELIZER_DPRAM_READER_LAST_EN
    logic        last1, last3;
`endif

    always #5 clk = ~clk;

    channelizer_dpram_reader #(.c_width(13), .c_address_width(4), .latency(1)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy1), .done(done1), .ram_addr(addr1), .ram_en(en1), .ram_dout(rd1),
        .dout(dout1), .dout_valid(valid1),
`ifdef CHANNELIZER_DPRAM_READER_LAST_EN
        .dout_last(last1),
`endif
        .dout_ready(dout_ready));

    channelizer_dpram_reader #(.c_width(13), .c_address_width(4), .latency(3)) dut3 (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy3), .done(done3), .ram_addr(addr3), .ram_en(en3), .ram_dout(rd3),
        .dout(dout3), .dout_valid(valid3),
`ifdef CHANNELIZER_DPRAM_READER_LAST_EN
        .dout_last(last3),
`endif
        .dout_ready(dout_ready));

    // RAM contents: mem[i] = 0xA00 + 0x11*i
    logic [12:0] mem [16];
    logic [12:0] r1;
    logic [12:0] p3 [3];
    initial for (int i = 0; i < 16; i++) mem[i] = 13'hA00 + 13'h11 * 13'(i);

    always_ff @(posedge clk) if (en1) r1 <= mem[addr1];
    always_ff @(posedge clk) begin
        if (en3) begin
            p3[0] <= mem[addr3];
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end
    assign rd1 = r1;
    assign rd3 = p3[2];

    int          sel;
    logic        s_busy, s_done, s_en, s_valid;
    logic [3:0]  s_addr;
    logic [12:0] s_dout;
    assign s_busy  = (sel == 1) ? busy3  : busy1;
    assign s_done  = (sel == 1) ? done3  : done1;
    assign s_en    = (sel == 1) ? en3    : en1;
    assign s_valid = (sel == 1) ? valid3 : valid1;
    assign s_addr  = (sel == 1) ? addr3  : addr1;
    assign s_dout  = (sel == 1) ? dout3  : dout1;

    typedef struct {
        int          sel;
        logic [3:0]  base;
        logic [4:0]  len;
        int          mode;      // 0: ready=1, 1: ready toggles 1010.., 2: ready=1 no throughput check
        int          exp_count;
        logic [12:0] exp_first;
        logic [12:0] exp_last;
        int          exp_lat;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc, first_vcyc, last_xcyc, done_cyc, mode, ce_off_from, ce_off_to;
    bit          saw_busy, saw_en, saw_valid;
    logic [12:0] got [$];
    logic [3:0]  addr_log [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Advance to the next negedge, sample outputs, then set inputs for the coming posedge.
    task automatic step();
        @(negedge clk);
        start = 1'b0;
        cyc++;
        if (s_busy)  saw_busy  = 1'b1;
        if (s_en)    saw_en    = 1'b1;
        if (s_valid) saw_valid = 1'b1;
        if (s_valid && first_vcyc < 0) first_vcyc = cyc;
        if (s_done && done_cyc < 0) done_cyc = cyc;
        if (cyc <= 4) addr_log[cyc-1] = s_addr;
        ce = !(cyc >= ce_off_from && cyc < ce_off_to);
        dout_ready = (mode != 1) || (cyc % 2 == 0);
        if (s_valid && dout_ready && ce) begin
            got.push_back(s_dout);
            last_xcyc = cyc;
        end
    endtask

    task automatic begin_burst(input int s, input logic [3:0] b, input logic [4:0] l, input int m);
        sel = s; mode = m; cyc = 0;
        first_vcyc = -1; last_xcyc = -1; done_cyc = -1;
        ce_off_from = -1; ce_off_to = -1;
        saw_busy = 1'b0; saw_en = 1'b0; saw_valid = 1'b0;
        got.delete();
        base_addr = b; len = l; start = 1'b1; dout_ready = 1'b1; ce = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        dout_ready = 1'b1;
        while ((busy1 || busy3 || done1 || done3) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", {31'd0, busy1 | busy3}, 32'd0);
    endtask

    task automatic check_vec(input vec_t v);
        logic [3:0]  a;
        logic [12:0] exp_w;
        chk("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
        chk("word_count", got.size(), v.exp_count);
        for (int i = 0; i < got.size() && i < v.exp_count; i++) begin
            a = v.base + 4'(i);
            exp_w = 13'hA00 + 13'h11 * {9'd0, a};
            chk("word", {19'd0, got[i]}, {19'd0, exp_w});
        end
        if (got.size() > 0) begin
            chk("first_word", {19'd0, got[0]}, {19'd0, v.exp_first});
            chk("last_word", {19'd0, got[got.size()-1]}, {19'd0, v.exp_last});
        end
        if (v.len != 0) begin
            chk("first_valid_latency", first_vcyc - 1, v.exp_lat);
            chk("done_after_last", done_cyc, last_xcyc + 1);
            if (v.mode == 0) chk("throughput_span", last_xcyc - first_vcyc, int'(v.len) - 1);
        end else begin
            chk("done_len0", done_cyc, 1);
            chk("idle_len0", {29'd0, saw_busy, saw_en, saw_valid}, 32'd0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        begin_burst(v.sel, v.base, v.len, v.mode);
        while (done_cyc < 0 && cyc < 400) step();
        repeat (3) step();
        check_vec(v);
    endtask

    vec_t        vecs [6];
    vec_t        v5, v6;
    logic [35:0] snap;
    bit          frozen_bad;

    initial begin
        vecs[0] = '{0, 4'd0,  5'd16, 0, 16, 13'hA00, 13'hAFF, 2};
        vecs[1] = '{0, 4'd14, 5'd4,  0, 4,  13'hAEE, 13'hA11, 2};
        vecs[2] = '{1, 4'd5,  5'd9,  1, 9,  13'hA55, 13'hADD, 4};
        vecs[3] = '{0, 4'd7,  5'd0,  0, 0,  13'h000, 13'h000, 0};
        vecs[4] = '{1, 4'd0,  5'd16, 0, 16, 13'hA00, 13'hAFF, 4};
        vecs[5] = '{0, 4'd15, 5'd1,  1, 1,  13'hAFF, 13'hAFF, 2};
        v5      = '{0, 4'd3,  5'd2,  0, 2,  13'hA33, 13'hA44, 2};
        v6      = '{0, 4'd0,  5'd8,  2, 8,  13'hA00, 13'hA77, 2};

        rst = 1'b1; ce = 1'b1; start = 1'b0; dout_ready = 1'b1;
        base_addr = '0; len = '0; sel = 0; mode = 0;
        ce_off_from = -1; ce_off_to = -1;
        repeat (2) @(negedge clk);
        chk("reset_dut1", {10'd0, busy1, done1, valid1, en1, addr1, dout1}, 32'd0);
        chk("reset_dut3", {10'd0, busy3, done3, valid3, en3, addr3, dout3}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            wait_idle();
            run_vec(vecs[i]);
            if (vecs[i].base == 4'd14 && vecs[i].sel == 0) begin
                chk("addr_seq0", {28'd0, addr_log[0]}, 32'd14);
                chk("addr_seq1", {28'd0, addr_log[1]}, 32'd15);
                chk("addr_seq2", {28'd0, addr_log[2]}, 32'd0);
                chk("addr_seq3", {28'd0, addr_log[3]}, 32'd1);
            end
        end

        // Reset in the middle of a burst, then a fresh short burst.
        wait_idle();
        begin_burst(0, 4'd0, 5'd16, 0);
        while (got.size() < 5 && cyc < 100) step();
        chk("reached_5_words", got.size(), 5);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {10'd0, busy1, done1, valid1, en1, addr1, dout1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(v5);

        // Clock enable low for 10 cycles mid-burst, then a start while busy.
        wait_idle();
        begin_burst(0, 4'd0, 5'd8, 2);
        ce_off_from = 3; ce_off_to = 13;
        repeat (3) step();
        snap = {s_dout, s_valid, s_addr, s_busy, s_done, 16'd0};
        frozen_bad = 1'b0;
        while (cyc < 13) begin
            step();
            if ({s_dout, s_valid, s_addr, s_busy, s_done, 16'd0} !== snap) frozen_bad = 1'b1;
            if (cyc < 13 && s_en) frozen_bad = 1'b1;
        end
        chk("ce_low_frozen", {31'd0, frozen_bad}, 32'd0);
        base_addr = 4'd9; len = 5'd2; start = 1'b1;
        while (done_cyc < 0 && cyc < 200) step();
        repeat (3) step();
        check_vec(v6);

        wait_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
